// File: rtl/wish_pack_arb_pkg.sv
// Shared types and width helpers for the Wishbone pack-datapath arbiter.
package wish_pack_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int idx_width(input int n_src);
        return clog2_min1(n_src);
    endfunction

    function automatic int cnt_width(input int n_pack);
        return clog2_min1(n_pack);
    endfunction

endpackage

// File: rtl/wish_pack_arb_rr.sv
// Combinational round-robin pick: first set request after the last winner, with wrap.
module rr_arbiter
    import wish_pack_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int            pos;
    logic          found;
    logic [IW-1:0] sel;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            sel = IW'(pos);
            if (!found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/wish_pack_arb.sv
// Shares one Wishbone packer source port among NUM_SRC masters, one full pack per grant.
//   state | meaning
//   IDLE  | no grant; arbitrate among requesting sources
//   BURST | source `last` owns the packer until NUM_PACK words are accepted
module wish_pack_arb
    import wish_pack_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TGC_WIDTH  = 2,
    parameter int NUM_PACK   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_SRC-1:0]            s_cyc_i,
    input  logic [NUM_SRC-1:0]            s_stb_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_dat_i,
    input  logic [NUM_SRC*TGC_WIDTH-1:0]  s_tgc_i,
    output logic [NUM_SRC-1:0]            s_ack_o,
    output logic [NUM_SRC-1:0]            s_stall_o,
    output logic                          m_cyc_o,
    output logic                          m_stb_o,
    output logic [DATA_WIDTH-1:0]         m_dat_o,
    output logic [TGC_WIDTH-1:0]          m_tgc_o,
    input  logic                          m_ack_i,
    input  logic                          m_stall_i,
    output logic [NUM_SRC-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IW = idx_width(NUM_SRC);
    localparam int CW = cnt_width(NUM_PACK);

    arb_state_t         state;
    logic [NUM_SRC-1:0] grant;
    logic [IW-1:0]      last;
    logic [CW-1:0]      wcnt;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               accept;

    assign req = s_cyc_i & s_stb_i;

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr (
        .req  (req),
        .last (last),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // In BURST, `last` is the granted index and drives the mux directly.
    always_comb begin
        m_cyc_o   = 1'b0;
        m_stb_o   = 1'b0;
        m_dat_o   = '0;
        m_tgc_o   = '0;
        s_ack_o   = '0;
        s_stall_o = '0;
        if (rst_n_i) begin
            s_stall_o = req;
            if (state == BURST) begin
                m_cyc_o         = s_cyc_i[last];
                m_stb_o         = s_stb_i[last];
                m_dat_o         = s_dat_i[int'(last)*DATA_WIDTH +: DATA_WIDTH];
                m_tgc_o         = s_tgc_i[int'(last)*TGC_WIDTH +: TGC_WIDTH];
                s_ack_o[last]   = m_ack_i & req[last];
                s_stall_o[last] = m_stall_i;
            end
        end
    end

    assign accept  = (state == BURST) && m_cyc_o && m_stb_o && m_ack_i;
    assign grant_o = grant;
    assign busy_o  = (state == BURST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(NUM_SRC - 1);
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= arb_gnt;
                        last  <= arb_idx;
                        wcnt  <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    // Grant is held until a full pack lands, even if the source pauses.
                    if (accept) begin
                        if (wcnt == CW'(NUM_PACK - 1)) begin
                            grant <= '0;
                            wcnt  <= '0;
                            state <= IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wish_pack_arb.sv
// Directed bench for wish_pack_arb: scoreboard of expected (source, word) acks plus grant/state checks.
module tb_wish_pack_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_cyc, s_stb, s_ack, s_stall, grant;
    logic [31:0] s_dat;
    logic [7:0]  s_tgc;
    logic        m_cyc, m_stb, m_ack, m_stall, busy;
    logic [7:0]  m_dat;
    logic [1:0]  m_tgc;

    logic [1:0]  s2_cyc, s2_stb, s2_ack, s2_stall, grant2;
    logic [15:0] s2_dat;
    logic [3:0]  s2_tgc;
    logic        m2_cyc, m2_stb, m2_ack, m2_stall, busy2;
    logic [7:0]  m2_dat;
    logic [1:0]  m2_tgc;

    always #5 clk = ~clk;

    wish_pack_arb #(.NUM_SRC(4), .DATA_WIDTH(8), .TGC_WIDTH(2), .NUM_PACK(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
        .s_ack_o(s_ack), .s_stall_o(s_stall),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_dat_o(m_dat), .m_tgc_o(m_tgc),
        .m_ack_i(m_ack), .m_stall_i(m_stall),
        .grant_o(grant), .busy_o(busy)
    );

    wish_pack_arb #(.NUM_SRC(2), .DATA_WIDTH(8), .TGC_WIDTH(2), .NUM_PACK(1)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_cyc_i(s2_cyc), .s_stb_i(s2_stb), .s_dat_i(s2_dat), .s_tgc_i(s2_tgc),
        .s_ack_o(s2_ack), .s_stall_o(s2_stall),
        .m_cyc_o(m2_cyc), .m_stb_o(m2_stb), .m_dat_o(m2_dat), .m_tgc_o(m2_tgc),
        .m_ack_i(m2_ack), .m_stall_i(m2_stall),
        .grant_o(grant2), .busy_o(busy2)
    );

    typedef struct {
        int         src;
        logic [7:0] dat;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] g2_q[$];
    int         word_cnt[4];
    int         next_push[4];
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [7:0] dat(input int i, input int k);
        return 8'((i << 6) + k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_dat();
        for (int i = 0; i < 4; i++) begin
            s_dat[i*8 +: 8] = dat(i, word_cnt[i]);
            s_tgc[i*2 +: 2] = 2'(i);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        s_cyc = r;
        s_stb = r;
    endtask

    task automatic push_words(input int src, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.src = src;
            e.dat = dat(src, next_push[src]);
            next_push[src]++;
            exp_q.push_back(e);
        end
    endtask

    // One clock: score any ack at the falling edge, then advance acked sources past the rising edge.
    task automatic step();
        logic [3:0] acked;
        exp_t       e;
        @(negedge clk);
        acked = s_ack;
        if (acked != 4'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(acked), 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_src", 32'(acked), 32'(1 << e.src));
                chk("m_dat", 32'(m_dat), 32'(e.dat));
                chk("m_tgc", 32'(m_tgc), 32'(e.src));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (acked[i]) word_cnt[i]++;
        drive_dat();
    endtask

    task automatic run_until_empty(input string tag, input int exp_steps);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 64) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_steps));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(4'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [1:0] g;
        rst_n   = 1'b0;
        s_cyc   = '0; s_stb = '0; s_dat = '0; s_tgc = '0;
        m_ack   = 1'b1;
        m_stall = 1'b0;
        s2_cyc  = '0; s2_stb = '0; s2_dat = 16'hBBAA; s2_tgc = 4'b1001;
        m2_ack  = 1'b1;
        m2_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            word_cnt[i]  = 0;
            next_push[i] = 0;
        end
        drive_dat();
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_m_cyc", 32'(m_cyc), 32'h0);
        chk("rst_m_dat", 32'(m_dat), 32'h0);
        chk("rst_s_stall", 32'(s_stall), 32'h0);
        do_reset();

        // Single source 2
        set_req(4'b0100);
        push_words(2, 4);
        #1;
        chk("t1_idle_stall", 32'(s_stall), 32'h4);
        chk("t1_idle_ack", 32'(s_ack), 32'h0);
        step();
        chk("t1_grant", 32'(grant), 32'h4);
        chk("t1_busy", 32'(busy), 32'h1);
        run_until_empty("t1_steps", 4);
        set_req(4'b0);
        chk("t1_busy_drop", 32'(busy), 32'h0);
        chk("t1_grant_drop", 32'(grant), 32'h0);

        // Round robin from reset: 0,1,2,3,0 with one idle bubble per grant
        do_reset();
        set_req(4'b1111);
        push_words(0, 4); push_words(1, 4); push_words(2, 4); push_words(3, 4); push_words(0, 4);
        run_until_empty("rr_steps", 25);
        set_req(4'b0);
        step();
        chk("rr_idle_after", 32'(busy), 32'h0);

        // Packer stall mid-burst on source 1
        set_req(4'b0010);
        push_words(1, 4);
        step(); step(); step();
        chk("st_q_before", 32'(exp_q.size()), 32'h2);
        m_ack   = 1'b0;
        m_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_stall_g", 32'(s_stall), 32'h2);
            chk("st_no_ack", 32'(s_ack), 32'h0);
            chk("st_grant", 32'(grant), 32'h2);
            step();
        end
        m_ack   = 1'b1;
        m_stall = 1'b0;
        run_until_empty("st_steps", 2);
        chk("st_release", 32'(busy), 32'h0);
        set_req(4'b0);

        // Source 2 pauses after two words while 0 and 3 wait
        set_req(4'b1101);
        push_words(2, 4);
        step(); step(); step();
        set_req(4'b1001);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("cd_grant", 32'(grant), 32'h4);
            chk("cd_no_ack", 32'(s_ack), 32'h0);
            chk("cd_stall", 32'(s_stall), 32'h9);
            chk("cd_m_cyc", 32'(m_cyc), 32'h0);
            step();
        end
        set_req(4'b1101);
        run_until_empty("cd_steps", 2);
        set_req(4'b1001);
        push_words(3, 1);
        step();
        chk("cd_rotate", 32'(grant), 32'h8);
        step();
        chk("ar_q_empty", 32'(exp_q.size()), 32'h0);

        // Async reset one word into source 3's burst
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_m_cyc", 32'(m_cyc), 32'h0);
        chk("ar_m_stb", 32'(m_stb), 32'h0);
        chk("ar_ack", 32'(s_ack), 32'h0);
        chk("ar_stall", 32'(s_stall), 32'h0);
        chk("ar_m_dat", 32'(m_dat), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push_words(0, 4);
        run_until_empty("ar_src0_steps", 4);
        set_req(4'b0);
        step();
        chk("ar_idle_after", 32'(busy), 32'h0);

        // NUM_PACK=1, two sources: alternating single-word grants
        s2_cyc = 2'b11;
        s2_stb = 2'b11;
        g2_q.push_back(2'b01); g2_q.push_back(2'b10);
        g2_q.push_back(2'b01); g2_q.push_back(2'b10);
        n = 0;
        while (g2_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (grant2 != 2'b00) begin
                g = g2_q.pop_front();
                chk("p1_grant", 32'(grant2), 32'(g));
                chk("p1_ack", 32'(s2_ack), 32'(g));
                chk("p1_dat", 32'(m2_dat), (g == 2'b01) ? 32'hAA : 32'hBB);
            end
        end
        chk("p1_cycles", 32'(n), 32'd7);
        s2_cyc = 2'b00;
        s2_stb = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
